// File: rtl/ci_top.sv
// Streaming circular-intensity bit statistics for radii 2/4/6/8 over a raster frame.
// A 16-row pixel delay line supplies all four axial neighbours when the lowest one arrives.
module ci_top #(
  parameter int COLS = 30,
  parameter int ROWS = 30
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  grayscale_i,
  input  logic        done_i,
  output logic [15:0] R2_bit_one_o,
  output logic [15:0] R2_bit_zero_o,
  output logic        done_R2,
  output logic [15:0] R4_bit_one_o,
  output logic [15:0] R4_bit_zero_o,
  output logic        done_R4,
  output logic [15:0] R6_bit_one_o,
  output logic [15:0] R6_bit_zero_o,
  output logic        done_R6,
  output logic [15:0] R8_bit_one_o,
  output logic [15:0] R8_bit_zero_o,
  output logic        done_R8
);

  localparam int DEPTH = 16*COLS + 1;

  // line_q[k] holds the pixel accepted k+1 acceptances ago; the incoming pixel is the "down" neighbour
  logic [7:0]  line_q [DEPTH];
  logic [15:0] row_q, col_q;
  logic        frame_end;
  logic        first_q, last_q, done_q;
  logic [3:0]  vld_d, bit_d, vld_q, bit_q;

  assign frame_end = (row_q == 16'(ROWS-1)) && (col_q == 16'(COLS-1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      row_q   <= '0;
      col_q   <= '0;
      first_q <= 1'b0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
      vld_q   <= '0;
      bit_q   <= '0;
      for (int i = 0; i < DEPTH; i++) line_q[i] <= '0;
    end else begin
      done_q  <= last_q;
      last_q  <= done_i && frame_end;
      first_q <= done_i && (row_q == '0) && (col_q == '0);
      vld_q   <= vld_d;
      bit_q   <= bit_d;
      if (done_i) begin
        line_q[0] <= grayscale_i;
        for (int i = 1; i < DEPTH; i++) line_q[i] <= line_q[i-1];
        if (col_q == 16'(COLS-1)) begin
          col_q <= '0;
          row_q <= frame_end ? '0 : row_q + 16'd1;
        end else begin
          col_q <= col_q + 16'd1;
        end
      end
    end
  end

  for (genvar g = 0; g < 4; g++) begin : g_rad
    localparam int R = 2*(g+1);
    logic [9:0]  sum_d, ctr4_d;
    logic [15:0] one_q, zero_q;

    assign sum_d  = 10'(line_q[2*R*COLS-1]) + 10'(line_q[R*COLS+R-1])
                  + 10'(line_q[R*COLS-R-1]) + 10'(grayscale_i);
    assign ctr4_d = {line_q[R*COLS-1], 2'b00};
    assign bit_d[g] = (ctr4_d >= sum_d);
    // current pixel is (r+R, c): centre row r = row_q-R must lie in [R, ROWS-1-R]
    assign vld_d[g] = done_i && (row_q >= 16'(2*R)) && (col_q >= 16'(R))
                    && (col_q <= 16'(COLS-1-R));

    // clearing one cycle late keeps the finished frame visible during the done pulse
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        one_q  <= '0;
        zero_q <= '0;
      end else if (first_q) begin
        one_q  <= '0;
        zero_q <= '0;
      end else if (vld_q[g]) begin
        if (bit_q[g]) begin
          if (one_q != 16'hFFFF) one_q <= one_q + 16'd1;
        end else begin
          if (zero_q != 16'hFFFF) zero_q <= zero_q + 16'd1;
        end
      end
    end
  end

  assign R2_bit_one_o  = g_rad[0].one_q;
  assign R2_bit_zero_o = g_rad[0].zero_q;
  assign R4_bit_one_o  = g_rad[1].one_q;
  assign R4_bit_zero_o = g_rad[1].zero_q;
  assign R6_bit_one_o  = g_rad[2].one_q;
  assign R6_bit_zero_o = g_rad[2].zero_q;
  assign R8_bit_one_o  = g_rad[3].one_q;
  assign R8_bit_zero_o = g_rad[3].zero_q;
  assign done_R2 = done_q;
  assign done_R4 = done_q;
  assign done_R6 = done_q;
  assign done_R8 = done_q;

endmodule

// File: tb/tb_ci_top.sv
// Directed bench for ci_top: constant, spike and dip frames, stalls, mid-frame reset, back-to-back frames.
module tb_ci_top;
  localparam int COLS = 30;
  localparam int ROWS = 30;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [7:0] grayscale_i = '0;
  logic done_i = 1'b0;
  logic [15:0] r2_one, r2_zero, r4_one, r4_zero, r6_one, r6_zero, r8_one, r8_zero;
  logic d2, d4, d6, d8;

  ci_top #(.COLS(COLS), .ROWS(ROWS)) dut (
    .clk(clk), .rst(rst), .grayscale_i(grayscale_i), .done_i(done_i),
    .R2_bit_one_o(r2_one), .R2_bit_zero_o(r2_zero), .done_R2(d2),
    .R4_bit_one_o(r4_one), .R4_bit_zero_o(r4_zero), .done_R4(d4),
    .R6_bit_one_o(r6_one), .R6_bit_zero_o(r6_zero), .done_R6(d6),
    .R8_bit_one_o(r8_one), .R8_bit_zero_o(r8_zero), .done_R8(d8)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int nerr = 0;
  int nchecks = 0;
  int t_last = 0;

  // per done pulse: captured counts, cycle, all-four flag, R2 one-count on the following cycle
  int pulses = 0;
  int h1 [32][4];
  int h0 [32][4];
  int dcyc [32];
  int all4 [32];
  int post1 [32];
  bit prev_done = 1'b0;

  always @(negedge clk) begin
    if (prev_done && pulses > 0 && pulses <= 32) post1[pulses-1] = int'(r2_one);
    if (d2 && pulses < 32) begin
      h1[pulses][0] = int'(r2_one); h0[pulses][0] = int'(r2_zero);
      h1[pulses][1] = int'(r4_one); h0[pulses][1] = int'(r4_zero);
      h1[pulses][2] = int'(r6_one); h0[pulses][2] = int'(r6_zero);
      h1[pulses][3] = int'(r8_one); h0[pulses][3] = int'(r8_zero);
      dcyc[pulses]  = cyc;
      all4[pulses]  = int'(d4 && d6 && d8);
      pulses++;
    end
    prev_done = d2;
  end

  task automatic chk(input string tag, input int obs, input int exp);
    nchecks++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] pix(input int mode, input int r, input int c);
    logic spot;
    spot = (r == 15) && (c == 15);
    case (mode)
      0: pix = 8'd100;
      1: pix = spot ? 8'd255 : 8'd0;
      default: pix = spot ? 8'd0 : 8'd255;
    endcase
  endfunction

  task automatic send(input int mode, input int n, input bit stall, input bit keep);
    for (int i = 0; i < n; i++) begin
      if (stall && i > 0 && (i % 7) == 0) begin
        @(negedge clk); done_i = 1'b0;
        @(negedge clk);
        @(negedge clk);
      end
      @(negedge clk);
      grayscale_i = pix(mode, i / COLS, i % COLS);
      done_i = 1'b1;
    end
    @(posedge clk); #1 t_last = cyc;
    if (!keep) begin
      @(negedge clk); done_i = 1'b0;
    end
  endtask

  task automatic wait_pulse(input int target);
    int n;
    n = 0;
    while (pulses < target && n < 40) begin
      @(posedge clk); #2;
      n++;
    end
    chk("pulse_count", pulses, target);
  endtask

  task automatic check_pulse(input string tag, input int idx, input int e[8]);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("%s_R%0d_one", tag, 2*(i+1)), h1[idx][i], e[2*i]);
      chk($sformatf("%s_R%0d_zero", tag, 2*(i+1)), h0[idx][i], e[2*i+1]);
    end
    chk({tag, "_all4"}, all4[idx], 1);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_r2"}, int'(r2_one) + int'(r2_zero), 0);
    chk({tag, "_r4"}, int'(r4_one) + int'(r4_zero), 0);
    chk({tag, "_r6"}, int'(r6_one) + int'(r6_zero), 0);
    chk({tag, "_r8"}, int'(r8_one) + int'(r8_zero), 0);
    chk({tag, "_done"}, int'({d2, d4, d6, d8}), 0);
  endtask

  int e_flat [8] = '{676, 0, 484, 0, 324, 0, 196, 0};
  int e_spk  [8] = '{672, 4, 480, 4, 320, 4, 196, 0};
  int e_dip  [8] = '{675, 1, 483, 1, 323, 1, 195, 1};

  initial begin
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst = 1'b1;

    send(0, ROWS*COLS, 1'b0, 1'b0);
    wait_pulse(1);
    check_pulse("flat", 0, e_flat);
    chk("flat_latency", dcyc[0], t_last + 1);
    repeat (5) @(negedge clk);
    chk("flat_hold", int'(r2_one), 676);
    chk("flat_single_pulse", pulses, 1);

    send(1, ROWS*COLS, 1'b0, 1'b0);
    wait_pulse(2);
    check_pulse("spike", 1, e_spk);

    send(2, ROWS*COLS, 1'b0, 1'b0);
    wait_pulse(3);
    check_pulse("dip", 2, e_dip);

    send(0, ROWS*COLS, 1'b1, 1'b0);
    wait_pulse(4);
    check_pulse("stall", 3, e_flat);
    chk("stall_latency", dcyc[3], t_last + 1);

    send(1, 400, 1'b0, 1'b0);
    chk("partial_nonzero", int'(r2_one != 16'd0), 1);
    rst = 1'b0;
    #1 check_zero("midreset");
    repeat (2) @(negedge clk);
    rst = 1'b1;
    send(1, ROWS*COLS, 1'b0, 1'b0);
    wait_pulse(5);
    check_pulse("after_reset", 4, e_spk);

    send(0, ROWS*COLS, 1'b0, 1'b1);
    send(1, ROWS*COLS, 1'b0, 1'b0);
    wait_pulse(7);
    check_pulse("b2b_first", 5, e_flat);
    chk("b2b_cleared", post1[5], 0);
    check_pulse("b2b_second", 6, e_spk);
    repeat (4) @(negedge clk);
    chk("total_pulses", pulses, 7);

    $display("Result: errors=%0d of %0d checks", nerr, nchecks);
    $finish;
  end
endmodule

// File: doc/ci_top.md
Name: ci_top

Overview:
- Streaming circular-intensity (CI) bit-statistics engine for a raster grayscale frame of ROWS x COLS 8-bit pixels.
- For each of four radii R in {2,4,6,8}, every interior pixel yields one CI bit: center vs. mean of its four axial neighbours at distance R.
- Counts of 1-bits and 0-bits per radius are reported at frame end.
- Sits after the grayscale conversion stage; its counts feed the texture-descriptor histogram stage.

Parameters:
- COLS, 30, pixels per row (>=17).
- ROWS, 30, rows per frame (>=17).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous reset, active-low.
- grayscale_i  in  8  pixel value, raster order (row-major, left to right).
- done_i  in  1  pixel-valid strobe; one pixel accepted per rising edge while high.
- R2_bit_one_o  out  16  count of CI bits = 1, R=2.
- R2_bit_zero_o  out  16  count of CI bits = 0, R=2.
- done_R2  out  1  one-cycle pulse, R=2 counts final.
- R4_bit_one_o / R4_bit_zero_o / done_R4  out  16/16/1  same for R=4.
- R6_bit_one_o / R6_bit_zero_o / done_R6  out  16/16/1  same for R=6.
- R8_bit_one_o / R8_bit_zero_o / done_R8  out  16/16/1  same for R=8.

Behaviour:
- Reset (rst=0, async): all count outputs 0; all done_R* 0; row/column position counters 0; pixel delay line contents 0.
- Pixel delay line:
  - Shift register of 16*COLS+1 entries, shifted only when done_i=1.
  - done_i=0 is a stall: no shift, no count change, no position advance.
- Position tracking: row/col counters track the accepted pixel. After pixel (ROWS-1, COLS-1) is accepted, the frame is complete and the next accepted pixel starts a new frame at (0,0).
- Valid positions for radius R: R <= r <= ROWS-1-R and R <= c <= COLS-1-R. Positions outside this range contribute nothing.
- CI bit per valid (r,c):
  - S = up(r-R,c) + down(r+R,c) + left(r,c-R) + right(r,c+R), 10-bit unsigned.
  - bit = 1 if 4*center >= S, else 0. Equality gives 1.
  - Evaluate when pixel (r+R, c) is accepted; all four neighbours are then present in the delay line.
- Counting and frame-end timing:
  - Counters are registered; a CI bit evaluated from the pixel accepted at edge k updates its counter at edge k+1.
  - Counters clear when the first pixel of a frame is accepted.
  - Counts hold their final value after frame end until the next frame's first pixel.
- done_R2..done_R8 go high at edge k+1 after the last frame pixel is accepted at edge k, then low at edge k+2, even if done_i remains high. All four pulse together.
- Per-frame invariant: bit_one + bit_zero = (ROWS-2R)*(COLS-2R). For 30x30: R2=676, R4=484, R6=324, R8=196.
- Widths: counts are 16-bit and saturate at 65535; they cannot overflow for ROWS*COLS <= 65535.
- Reset mid-frame: partial frame discarded; the next accepted pixel is (0,0).
- Simultaneous end of frame and done_i still high: the next pixel begins a new frame. done pulses still occur, with values of the completed frame visible in the done cycle.

Test Plan:
- All pixels 100, 30x30, done_i continuous -> done_R* pulse once, 1 cycle after the last pixel. R2 one=676 zero=0; R4 484/0; R6 324/0; R8 196/0.
- All 0 except (15,15)=255 -> R2 one=672 zero=4; R4 480/4; R6 320/4; R8 196/0 (R8 neighbours of (15,15) fall outside the valid range).
- All 255 except (15,15)=0 -> R2 675/1; R4 483/1; R6 323/1; R8 195/1.
- Same frame as the first scenario with done_i low for 3 cycles every 7 pixels -> identical counts; done pulses exactly 1 cycle after the 900th accepted pixel.
- Reset asserted after 400 pixels, then a full single-spike (255 at (15,15)) frame -> outputs 0 during reset; final counts match the second scenario.
- Two back-to-back frames (constant 100, then single spike) with no gap -> first done pulse shows 676/0 for R2; second shows 672/4; counts clear at the start of frame 2.
